// File: rtl/rx_tlp_receive_buffer_if.sv
// Bus bundle for the TLP receive buffer: DLL-side ingress, TL-side egress,
// flow-control credit release and occupancy.
interface rx_tlp_receive_buffer_if #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 1024
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] dll_tlp_data;
    logic              dll_tlp_valid;
    logic              dll_tlp_ready;
    logic [DATA_W-1:0] tl_tlp_data;
    logic              tl_tlp_valid;
    logic              tl_tlp_ready;
    logic [1:0]        tl_tlp_class;
    logic              fc_rel_valid;
    logic [1:0]        fc_rel_class;
    logic [8:0]        fc_rel_data_credits;
    logic [CNT_W-1:0]  occupancy;

    // Environment side: the DLL producer plus the TL consumer.
    modport master (
        output dll_tlp_data, dll_tlp_valid, tl_tlp_ready,
        input  dll_tlp_ready, tl_tlp_data, tl_tlp_valid, tl_tlp_class,
        input  fc_rel_valid, fc_rel_class, fc_rel_data_credits, occupancy
    );

    // Buffer side.
    modport slave (
        input  dll_tlp_data, dll_tlp_valid, tl_tlp_ready,
        output dll_tlp_ready, tl_tlp_data, tl_tlp_valid, tl_tlp_class,
        output fc_rel_valid, fc_rel_class, fc_rel_data_credits, occupancy
    );
endinterface

// File: rtl/rx_tlp_receive_buffer.sv
// Transaction-layer RX buffer: FIFO of validated TLPs, classified P/NP/CPL at
// push time, with a one-cycle credit-release pulse after each drain.
module rx_tlp_receive_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    rx_tlp_receive_buffer_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        CLS_P   = 2'b00,
        CLS_NP  = 2'b01,
        CLS_CPL = 2'b10
    } tlp_class_e;

    function automatic tlp_class_e classify(input logic [31:0] dw0);
        logic [2:0] fmt;
        logic [4:0] typ;
        fmt = dw0[31:29];
        typ = dw0[28:24];
        if (typ == 5'b01010)
            return CLS_CPL;
        else if (typ[4:3] == 2'b10)
            return CLS_P;
        else if (typ == 5'b00000 && fmt[1])
            return CLS_P;
        else
            return CLS_NP;
    endfunction

    // Length 0 encodes 1024 DW, which rounds up to exactly 256 credits.
    function automatic logic [8:0] data_credits(input logic [31:0] dw0);
        logic [10:0] len;
        logic [10:0] sum;
        len = (dw0[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw0[9:0]};
        sum = len + 11'd3;
        return dw0[30] ? sum[10:2] : 9'd0;
    endfunction

    logic [DATA_W-1:0] data_mem [DEPTH];
    tlp_class_e        cls_mem  [DEPTH];
    logic [8:0]        cred_mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              tl_valid;
    logic              dll_ready;
    logic              push;
    logic              pop;
    logic              fc_valid;
    tlp_class_e        fc_cls;
    logic [8:0]        fc_cred;

    assign tl_valid  = (count != '0);
    assign dll_ready = (count != FULL_CNT) && !reset;
    assign push      = bus.dll_tlp_valid && dll_ready;
    assign pop       = tl_valid && bus.tl_tlp_ready;

    // Storage is not reset; the head view is forced to zero whenever empty.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= bus.dll_tlp_data;
            cls_mem[wr_ptr]  <= classify(bus.dll_tlp_data[31:0]);
            cred_mem[wr_ptr] <= data_credits(bus.dll_tlp_data[31:0]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fc_valid <= 1'b0;
            fc_cls   <= CLS_P;
            fc_cred  <= '0;
        end else begin
            fc_valid <= pop;
            if (pop) begin
                fc_cls  <= cls_mem[rd_ptr];
                fc_cred <= cred_mem[rd_ptr];
            end
        end
    end

    assign bus.dll_tlp_ready       = dll_ready;
    assign bus.tl_tlp_valid        = tl_valid;
    assign bus.tl_tlp_data         = tl_valid ? data_mem[rd_ptr] : '0;
    assign bus.tl_tlp_class        = tl_valid ? cls_mem[rd_ptr] : CLS_P;
    assign bus.fc_rel_valid        = fc_valid;
    assign bus.fc_rel_class        = fc_cls;
    assign bus.fc_rel_data_credits = fc_cred;
    assign bus.occupancy           = count;

endmodule

// File: doc/rx_tlp_receive_buffer.md
Name: rx_tlp_receive_buffer

Overview:
Transaction-layer receive buffer. It sits directly downstream of the RX data link layer and accepts TLPs that have already passed the LCRC and sequence checks. It stores the TLPs in a small FIFO, classifies each one as Posted, Non-Posted or Completion, and presents them to the transaction-layer consumer. When a TLP is drained, it emits a flow-control credit-release pulse for the TX side's UpdateFC DLLP generation.

Parameters:
DEPTH, 4, FIFO entries; power of 2, minimum 2
DATA_W, 1024, TLP bus width in bits; the header occupies bits [127:0] and DW0 is bits [31:0]

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
dll_tlp_data  in  DATA_W  TLP from RX data link layer
dll_tlp_valid  in  1  TLP valid
dll_tlp_ready  out  1  buffer can accept a TLP
tl_tlp_data  out  DATA_W  head-of-FIFO TLP
tl_tlp_valid  out  1  head TLP valid
tl_tlp_ready  in  1  consumer accepts head TLP
tl_tlp_class  out  2  class of head TLP: 00 P, 01 NP, 10 CPL, 11 never driven
fc_rel_valid  out  1  one-cycle credit-release pulse
fc_rel_class  out  2  class of released TLP
fc_rel_data_credits  out  9  data credits released (0..256)
occupancy  out  $clog2(DEPTH)+1  entries currently stored

Behaviour:
- Reset:
  - All outputs are 0; read/write pointers and count are cleared.
  - Stored entries are discarded and produce no fc_rel pulse.
  - Reset asserted mid-transfer aborts everything; the first cycle after deassertion is the empty state.
- Push:
  - Occurs when dll_tlp_valid && dll_tlp_ready.
  - dll_tlp_ready = (count != DEPTH). It depends only on registered count; there is no combinational path from tl_tlp_ready.
  - When full, a push is refused even in a cycle where a pop occurs.
- Pop:
  - Occurs when tl_tlp_valid && tl_tlp_ready.
  - tl_tlp_valid = (count != 0).
  - tl_tlp_data and tl_tlp_class are driven from registered storage at the read pointer and stay stable while valid && !ready.
- Latency: a TLP pushed in cycle N into an empty buffer shows tl_tlp_valid=1 in cycle N+1. There is no same-cycle bypass.
- Simultaneous push and pop (count not 0 and not DEPTH): count is unchanged and both pointers advance.
- Pointers are log2(DEPTH) bits, wrap modulo DEPTH, and use a separate count register for full/empty.
- Classification is computed at push time from DW0 and stored alongside the data. Fields: fmt = [31:29], type = [28:24].
  - type == 5'b01010 -> CPL (covers Cpl and CplD).
  - type[4:3] == 2'b10 -> P (Msg/MsgD).
  - type == 5'b00000 && fmt[1] == 1 -> P (MWr).
  - All other encodings -> NP.
- Data credits are computed at push time and stored.
  - If fmt[1] == 0 (no payload), credits = 0.
  - Otherwise len = DW0[9:0] with 0 meaning 1024 DW; credits = ceil(len/4), so len=0 gives 256, len=1 gives 1, len=4 gives 1, len=5 gives 2.
  - Arithmetic is 11-bit with zero-extended len.
- Credit release: on each pop in cycle N, in cycle N+1 fc_rel_valid=1 and fc_rel_class / fc_rel_data_credits carry that entry's stored values. fc_rel_valid is 0 in every cycle without a preceding pop. Back-to-back pops give back-to-back pulses.
- occupancy equals count and is registered.
- Malformed TLPs are not checked here; the upstream layer has already filtered them.

Test Plan:
1. After reset, push one MWr with fmt=3'b010, type=0, len=8 -> tl_tlp_valid in the next cycle with class 00; pop it -> the following cycle shows fc_rel_valid=1, class=00, credits=2.
2. Push MRd (fmt=000, type=0), CplD (fmt=010, type=01010, len=0), and Msg (fmt=001, type=10000) -> classes 01, 10, 00 in order; release credits 0, 256, 0.
3. Hold tl_tlp_ready=0 and push DEPTH TLPs -> occupancy=4 and dll_tlp_ready=0; a 5th valid is held off; raise ready for one cycle with the 5th valid present -> one pop, no push, occupancy=3.
4. With occupancy=2, push and pop in the same cycle for 10 consecutive cycles -> occupancy stays 2, output order matches input order across pointer wrap, and 10 fc_rel pulses occur.
5. Fill 3 entries, then assert reset mid-stream -> all outputs 0 immediately; after deassertion occupancy=0 and no fc_rel pulse appears.
6. Backpressure with tl_tlp_ready toggling pseudo-randomly -> tl_tlp_data and tl_tlp_class stay stable while valid && !ready, and the scoreboard shows an exact in-order match.
